// File: rtl/pdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_pkg
//  Description : Shared constants and helpers for the PCM-to-PDM modulator.
//                PCM_W    - PCM sample width (signed)
//                INTERP_R - PDM bit-ticks per PCM sample
//                ACC_W    - sigma-delta integrator width (signed)
//                sat_acc  - saturating a + b - c at integrator width
//  Revision    : 1.0 - initial release
// ============================================================================
package pdm_pkg;

    localparam int PCM_W    = 16;
    localparam int INTERP_R = 10;
    localparam int ACC_W    = PCM_W + 4;

    // Feedback magnitudes: the PDM bit maps to +/- full-scale PCM.
    localparam logic signed [ACC_W-1:0] FS_POS = ACC_W'(1 << (PCM_W - 1));
    localparam logic signed [ACC_W-1:0] FS_NEG = -FS_POS;

    // Computes a + b - c at full precision (two guard bits cover the worst
    // case) and clamps to the ACC_W signed range, so integrators never wrap.
    function automatic logic signed [ACC_W-1:0] sat_acc(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b,
        input logic signed [ACC_W-1:0] c
    );
        logic signed [ACC_W+1:0] s;
        logic signed [ACC_W+1:0] lim_hi;
        logic signed [ACC_W+1:0] lim_lo;
        lim_hi = $signed({3'b000, {(ACC_W-1){1'b1}}});
        lim_lo = $signed({3'b111, {(ACC_W-1){1'b0}}});
        s = $signed({{2{a[ACC_W-1]}}, a})
          + $signed({{2{b[ACC_W-1]}}, b})
          - $signed({{2{c[ACC_W-1]}}, c});
        if (s > lim_hi) begin
            sat_acc = lim_hi[ACC_W-1:0];
        end else if (s < lim_lo) begin
            sat_acc = lim_lo[ACC_W-1:0];
        end else begin
            sat_acc = s[ACC_W-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_modulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_modulator_if
//  Description : Sample handshake and PDM status bundle.
//                master - sample source / PDM consumer (drives we, sample_*)
//                slave  - the modulator (drives ready, pdm_out, status pulses)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pdm_modulator_if
    import pdm_pkg::*;
#(
    parameter int N = PCM_W
);
    logic         we;
    logic [N-1:0] sample_in;
    logic         sample_valid;
    logic         sample_ready;
    logic         pdm_out;
    logic         sample_tick;
    logic         underrun;

    modport master (
        output we, sample_in, sample_valid,
        input  sample_ready, pdm_out, sample_tick, underrun
    );

    modport slave (
        input  we, sample_in, sample_valid,
        output sample_ready, pdm_out, sample_tick, underrun
    );
endinterface
`default_nettype wire

// File: rtl/pdm_sdm2.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_sdm2
//  Description : Second-order saturating sigma-delta core.
//                clk, rst - clock, synchronous active-high reset
//                i_we     - bit-rate enable; state advances only when high
//                i_x      - signed PCM input (held for the whole frame)
//                o_bit    - registered PDM output bit
//  Revision    : 1.0 - initial release
// ============================================================================
module pdm_sdm2
    import pdm_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_we,
    input  wire logic [PCM_W-1:0] i_x,
    output logic                  o_bit
);
    logic signed [ACC_W-1:0] r_int1;
    logic signed [ACC_W-1:0] r_int2;
    logic                    r_bit;

    logic signed [ACC_W-1:0] w_x;
    logic signed [ACC_W-1:0] w_fb;
    logic signed [ACC_W-1:0] w_int1_n;
    logic signed [ACC_W-1:0] w_int2_n;

    assign w_x      = {{(ACC_W-PCM_W){i_x[PCM_W-1]}}, i_x};
    assign w_fb     = r_bit ? FS_POS : FS_NEG;
    assign w_int1_n = sat_acc(r_int1, w_x, w_fb);
    // Second stage integrates the already-updated first stage.
    assign w_int2_n = sat_acc(r_int2, w_int1_n, w_fb);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_int1 <= '0;
            r_int2 <= '0;
            r_bit  <= 1'b0;
        end else if (i_we) begin
            r_int1 <= w_int1_n;
            r_int2 <= w_int2_n;
            r_bit  <= ~w_int2_n[ACC_W-1];
        end
    end

    assign o_bit = r_bit;
endmodule
`default_nettype wire

// File: rtl/pdm_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_modulator
//  Description : PCM to 1-bit PDM modulator with zero-order-hold
//                interpolation by R and a one-entry sample holding register.
//                clk, rst - clock, synchronous active-high reset
//                bus      - slave side of pdm_modulator_if:
//                           we (bit enable), sample_in/valid/ready handshake,
//                           pdm_out, sample_tick and underrun pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module pdm_modulator
    import pdm_pkg::*;
#(
    parameter int R = INTERP_R
)(
    input  wire logic       clk,
    input  wire logic       rst,
    pdm_modulator_if.slave  bus
);
    localparam int CNT_W = 8;

    logic [PCM_W-1:0] r_hold;
    logic             r_hold_full;
    logic [PCM_W-1:0] r_cur_sample;
    logic [CNT_W-1:0] r_bit_cnt;

    logic             w_boundary;
    logic             w_accept;

    assign w_boundary = bus.we && (r_bit_cnt == CNT_W'(R - 1));
    // Ready comes straight from the register, so a boundary that empties
    // the hold cannot accept in the same cycle; ready rises one cycle later.
    assign w_accept   = bus.sample_valid && !r_hold_full;

    assign bus.sample_ready = !r_hold_full;
    assign bus.sample_tick  = w_boundary &&  r_hold_full;
    assign bus.underrun     = w_boundary && !r_hold_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_cur_sample <= '0;
            r_bit_cnt    <= '0;
        end else begin
            if (bus.we) begin
                r_bit_cnt <= w_boundary ? '0 : r_bit_cnt + 1'b1;
            end
            // On an empty hold the current sample simply repeats.
            if (w_boundary && r_hold_full) begin
                r_cur_sample <= r_hold;
                r_hold_full  <= 1'b0;
            end
            // Mutually exclusive with the load above (needs an empty hold).
            if (w_accept) begin
                r_hold      <= bus.sample_in;
                r_hold_full <= 1'b1;
            end
        end
    end

    pdm_sdm2 u_sdm (
        .clk   (clk),
        .rst   (rst),
        .i_we  (bus.we),
        .i_x   (r_cur_sample),
        .o_bit (bus.pdm_out)
    );
endmodule
`default_nettype wire

// File: tb/tb_pdm_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pdm_modulator
//  Description : Self-checking bench for pdm_modulator. A cycle model of the
//                handshake, frame counter and saturating sigma-delta loop
//                pushes expected outputs to a scoreboard queue each cycle;
//                directed checks cover densities, backpressure, underrun,
//                we gating and mid-frame reset replay.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_modulator;
    import pdm_pkg::*;

    localparam int     R    = INTERP_R;
    localparam longint FS   = 64'sd1 <<< (PCM_W - 1);
    localparam longint AMAX = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (ACC_W - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pdm_modulator_if bus ();

    pdm_modulator #(.R(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic   ready;
        logic   tick;
        logic   under;
        logic   pdm;
        longint i1;
        longint i2;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic        m_full;
    logic        m_pdm;
    longint      m_i1, m_i2;
    logic [15:0] m_hold, m_cur;
    int          m_cnt;

    // Observation statistics
    int   c_ones, c_ready, c_under, c_tick;
    int   rec_mode;
    int   rec_idx;
    int   rec_mis;
    logic rec_bits [2000];

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v > AMAX) return AMAX;
        if (v < AMIN) return AMIN;
        return v;
    endfunction

    task automatic model_reset();
        m_full = 1'b0; m_pdm = 1'b0; m_i1 = 0; m_i2 = 0;
        m_hold = '0;   m_cur = '0;   m_cnt = 0;
    endtask

    task automatic clear_stats();
        c_ones = 0; c_ready = 0; c_under = 0; c_tick = 0;
    endtask

    task automatic step(input logic s_rst, input logic s_we, input logic s_valid,
                        input logic [15:0] s_data);
        exp_t   e;
        exp_t   g;
        logic   bnd;
        logic   acc;
        longint x;
        longint fb;
        @(posedge clk);
        #1;
        rst              = s_rst;
        bus.we           = s_we;
        bus.sample_valid = s_valid;
        bus.sample_in    = s_data;

        bnd     = s_we && (m_cnt == R - 1);
        e.ready = !m_full;
        e.tick  = bnd && m_full;
        e.under = bnd && !m_full;
        e.pdm   = m_pdm;
        e.i1    = m_i1;
        e.i2    = m_i2;
        sb.push_back(e);

        if (s_rst) begin
            model_reset();
        end else begin
            acc = s_valid && !m_full;
            if (s_we) begin
                x     = longint'($signed(m_cur));
                fb    = m_pdm ? FS : -FS;
                m_i1  = clamp(m_i1 + x - fb);
                m_i2  = clamp(m_i2 + m_i1 - fb);
                m_pdm = (m_i2 >= 0);
                m_cnt = bnd ? 0 : m_cnt + 1;
            end
            if (bnd && m_full) begin
                m_cur  = m_hold;
                m_full = 1'b0;
            end
            if (acc) begin
                m_hold = s_data;
                m_full = 1'b1;
            end
        end

        @(negedge clk);
        g = sb.pop_front();
        check("ready",    bus.sample_ready, g.ready);
        check("tick",     bus.sample_tick,  g.tick);
        check("underrun", bus.underrun,     g.under);
        check("pdm_out",  bus.pdm_out,      g.pdm);
        check("int1",     dut.u_sdm.r_int1, g.i1);
        check("int2",     dut.u_sdm.r_int2, g.i2);

        if (bus.pdm_out === 1'b1)      c_ones++;
        if (bus.sample_ready === 1'b1) c_ready++;
        if (bus.underrun === 1'b1)     c_under++;
        if (bus.sample_tick === 1'b1)  c_tick++;
        if (rec_mode == 1 && rec_idx < 2000) begin
            rec_bits[rec_idx] = bus.pdm_out;
            rec_idx++;
        end else if (rec_mode == 2 && rec_idx < 2000) begin
            if (bus.pdm_out !== rec_bits[rec_idx]) rec_mis++;
            rec_idx++;
        end
    endtask

    task automatic run_dc(input int n, input logic [15:0] v, input int win_start);
        for (int i = 0; i < n; i++) begin
            if (i == win_start) clear_stats();
            step(1'b0, 1'b1, 1'b1, v);
        end
    endtask

    initial begin
        int total_under;
        int guard;
        bus.we = 1'b0; bus.sample_valid = 1'b0; bus.sample_in = '0;
        model_reset();
        clear_stats();
        rec_mode = 0; rec_idx = 0; rec_mis = 0;
        repeat (2) @(posedge clk);

        // Zero input, recorded for the reset replay later
        rec_mode = 1;
        step(1'b0, 1'b1, 1'b1, 16'h0000);
        check("rst_pdm",   bus.pdm_out,      0);
        check("rst_ready", bus.sample_ready, 1);
        check("rst_cnt",   dut.r_bit_cnt,    0);
        total_under = c_under;
        for (int i = 1; i < 2000; i++) begin
            if (i == 1000) begin
                total_under += c_under;
                clear_stats();
            end
            step(1'b0, 1'b1, 1'b1, 16'h0000);
        end
        total_under += c_under;
        rec_mode = 0;
        check("zero_density_ok", (c_ones >= 498 && c_ones <= 502), 1);
        check("zero_ready_count", c_ready, 100);
        check("zero_underrun",    total_under, 0);

        // DC +0.5 then -0.5
        run_dc(4000, 16'h4000, 2000);
        check("p05_density_ok", (c_ones >= 1480 && c_ones <= 1520), 1);
        run_dc(2200, 16'hC000, 200);
        check("m05_density_ok", (c_ones >= 480 && c_ones <= 520), 1);

        // Full scale both ways; integrator checks in step guard saturation
        run_dc(5000, 16'h7FFF, 1000);
        check("fs_pos_density_ok", (c_ones >= 3960), 1);
        run_dc(5000, 16'h8000, 1000);
        check("fs_neg_density_ok", (c_ones <= 40), 1);

        // Backpressure: drain to an empty hold first
        guard = 0;
        do begin
            step(1'b0, 1'b1, 1'b0, 16'h0000);
            guard++;
        end while (m_full && guard < 50);
        check("drain_timeout", guard < 50, 1);
        step(1'b0, 1'b1, 1'b1, 16'h1111);
        clear_stats();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 16'h1234);
        check("bp_ready_low", bus.sample_ready, 0);
        check("bp_hold_kept", dut.r_hold, 16'h1111);
        guard = 0;
        while (c_tick < 2 && guard < 40) begin
            step(1'b0, 1'b1, 1'b1, 16'h1234);
            guard++;
        end
        check("bp_tick_timeout", guard < 40, 1);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        check("bp_cur_sample", dut.r_cur_sample, 16'h1234);

        // Underrun: three empty frames
        clear_stats();
        for (int i = 0; i < 3 * R; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);
        check("underrun_count", c_underr_get(), 3);
        check("underrun_cur_kept", dut.r_cur_sample, 16'h1234);

        // we at quarter rate: ten enabled cycles span exactly one boundary
        clear_stats();
        for (int i = 0; i < 4 * R; i++) step(1'b0, (i % 4) == 0, 1'b0, 16'h0000);
        check("we_gated_underrun", c_under, 1);

        // Reset mid-frame with a full hold, then replay zero input
        guard = 0;
        while (!(m_cnt == 5 && m_full) && guard < 100) begin
            step(1'b0, 1'b1, 1'b1, 16'h0100);
            guard++;
        end
        check("mid_frame_timeout", guard < 100, 1);
        step(1'b1, 1'b1, 1'b1, 16'h0100);
        rec_mode = 2; rec_idx = 0; rec_mis = 0;
        step(1'b0, 1'b1, 1'b1, 16'h0000);
        check("mrst_pdm",   bus.pdm_out,      0);
        check("mrst_ready", bus.sample_ready, 1);
        check("mrst_cnt",   dut.r_bit_cnt,    0);
        for (int i = 1; i < 2000; i++) step(1'b0, 1'b1, 1'b1, 16'h0000);
        rec_mode = 0;
        check("replay_mismatches", rec_mis, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    function automatic int c_underr_get();
        return c_under;
    endfunction

endmodule
`default_nettype wire
